// File: rtl/logicalunit_arbiter.sv
// Round-robin arbiter sharing one bit-serial 2-input LUT (out = func[{a,b}])
// between NREQ requesters; each job returns a WIDTH-bit result tagged with its owner.
module logicalunit_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int IDW   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] a_in,
    input  logic [NREQ*WIDTH-1:0] b_in,
    input  logic [NREQ*4-1:0]     func_in,
    output logic [NREQ-1:0]       gnt,
    output logic                  busy,
    output logic [WIDTH-1:0]      result,
    output logic                  result_valid,
    output logic [IDW-1:0]        result_id
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    logic [IDW-1:0]   last_grant;
    logic [IDW-1:0]   cur_id;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [3:0]       func_r;

    logic             found;
    logic [IDW-1:0]   pick;
    logic             out_bit;
    logic [WIDTH:0]   res_ext;
    logic [WIDTH-1:0] res_next;

    // Search starts just after the last grant so that requester has lowest priority.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int i = 1; i <= NREQ; i++) begin
            if (!found && req[(int'(last_grant) + i) % NREQ]) begin
                found = 1'b1;
                pick  = IDW'((int'(last_grant) + i) % NREQ);
            end
        end
    end

    assign gnt      = (state == IDLE && found && !rst) ? (NREQ'(1) << pick) : '0;
    assign busy     = (state != IDLE);
    assign out_bit  = func_r[{a_sr[0], b_sr[0]}];
    assign res_ext  = {out_bit, res_sr};
    assign res_next = res_ext[WIDTH:1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            last_grant   <= IDW'(NREQ - 1);
            cur_id       <= '0;
            cnt          <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            result_id    <= '0;
        end else begin
            result_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        last_grant <= pick;
                        cur_id     <= pick;
                        cnt        <= '0;
                        state      <= SHIFT;
                    end
                end
                SHIFT: begin
                    cnt <= cnt + 1'b1;
                    // The final bit is folded in directly so the result appears during DONE.
                    if (cnt == CW'(WIDTH - 1)) begin
                        state        <= DONE;
                        result       <= res_next;
                        result_id    <= cur_id;
                        result_valid <= 1'b1;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Operand and result shift registers carry no reset; control qualifies them.
    always_ff @(posedge clk) begin
        if (state == IDLE && found) begin
            a_sr   <= a_in[int'(pick)*WIDTH +: WIDTH];
            b_sr   <= b_in[int'(pick)*WIDTH +: WIDTH];
            func_r <= func_in[int'(pick)*4 +: 4];
            res_sr <= '0;
        end else if (state == SHIFT) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            res_sr <= res_next;
        end
    end

endmodule
